// File: rtl/rvfi_bus_observer.sv
// Passive observer for one split request/response memory port. It pairs each accepted request
// with its in-order response and emits one registered RVFI bus-channel record per transfer.
module rvfi_bus_observer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned BUSLEN = 32,
  parameter int unsigned DEPTH  = 4,
  parameter bit          INSN   = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  input  logic                       req_ready_i,
  input  logic [XLEN-1:0]            req_addr_i,
  input  logic [BUSLEN/8-1:0]        req_rmask_i,
  input  logic [BUSLEN/8-1:0]        req_wmask_i,
  input  logic [BUSLEN-1:0]          req_wdata_i,
  input  logic                       rsp_valid_i,
  input  logic [BUSLEN-1:0]          rsp_rdata_i,
  input  logic                       rsp_err_i,
  output logic                       rvfi_bus_valid_o,
  output logic                       rvfi_bus_insn_o,
  output logic                       rvfi_bus_data_o,
  output logic                       rvfi_bus_fault_o,
  output logic [XLEN-1:0]            rvfi_bus_addr_o,
  output logic [BUSLEN/8-1:0]        rvfi_bus_rmask_o,
  output logic [BUSLEN-1:0]          rvfi_bus_rdata_o,
  output logic [BUSLEN/8-1:0]        rvfi_bus_wmask_o,
  output logic [BUSLEN-1:0]          rvfi_bus_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic                       proto_err_o
);

  localparam int unsigned NBytes = BUSLEN / 8;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  function automatic logic [BUSLEN-1:0] mask_bytes(input logic [BUSLEN-1:0] d,
                                                   input logic [NBytes-1:0] m);
    logic [BUSLEN-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NBytes); i++) begin
      r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  logic [XLEN-1:0]   addr_mem  [DEPTH];
  logic [NBytes-1:0] rmask_mem [DEPTH];
  logic [NBytes-1:0] wmask_mem [DEPTH];
  logic [BUSLEN-1:0] wdata_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            empty, full, req_fire, do_pop, do_push;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(DEPTH));
  assign req_fire = req_valid_i && req_ready_i;
  assign do_pop   = rsp_valid_i && !empty;
  // A pop in the same cycle frees the slot, so a push while full is only legal alongside a pop.
  assign do_push  = req_fire && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
    if ((rsp_valid_i && empty) || (req_fire && !do_push)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_mem[wr_ptr_q]  <= req_addr_i;
      rmask_mem[wr_ptr_q] <= req_rmask_i;
      wmask_mem[wr_ptr_q] <= req_wmask_i;
      wdata_mem[wr_ptr_q] <= req_wdata_i;
    end
  end

  // Record fields hold between pulses; only valid drops back to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvfi_bus_valid_o <= 1'b0;
      rvfi_bus_insn_o  <= 1'b0;
      rvfi_bus_data_o  <= 1'b0;
      rvfi_bus_fault_o <= 1'b0;
      rvfi_bus_addr_o  <= '0;
      rvfi_bus_rmask_o <= '0;
      rvfi_bus_rdata_o <= '0;
      rvfi_bus_wmask_o <= '0;
      rvfi_bus_wdata_o <= '0;
    end else begin
      rvfi_bus_valid_o <= do_pop;
      if (do_pop) begin
        rvfi_bus_insn_o  <= INSN;
        rvfi_bus_data_o  <= !INSN;
        rvfi_bus_fault_o <= rsp_err_i;
        rvfi_bus_addr_o  <= addr_mem[rd_ptr_q];
        rvfi_bus_rmask_o <= rmask_mem[rd_ptr_q];
        rvfi_bus_rdata_o <= mask_bytes(rsp_rdata_i, rmask_mem[rd_ptr_q]);
        rvfi_bus_wmask_o <= wmask_mem[rd_ptr_q];
        rvfi_bus_wdata_o <= mask_bytes(wdata_mem[rd_ptr_q], wmask_mem[rd_ptr_q]);
      end
    end
  end

  assign pending_o   = cnt_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_rvfi_bus_observer.sv
// Bench for rvfi_bus_observer: directed scenarios plus random traffic, checked every cycle
// against a queue-based transaction model. A second instance covers the instruction-port build.
module tb_rvfi_bus_observer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata = '0;
  logic [3:0]  req_rmask = '0, req_wmask = '0;

  logic        d_valid, d_insn, d_data, d_fault, d_err;
  logic [31:0] d_addr, d_rdata, d_wdata;
  logic [3:0]  d_rmask, d_wmask;
  logic [2:0]  d_pend;
  logic        i_valid, i_insn, i_data, i_fault, i_err;
  logic [31:0] i_addr, i_rdata, i_wdata;
  logic [3:0]  i_rmask, i_wmask;
  logic [2:0]  i_pend;

  always #5 clk = ~clk;

  rvfi_bus_observer #(.XLEN(32), .BUSLEN(32), .DEPTH(DEPTH), .INSN(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_i(req_ready),
    .req_addr_i(req_addr), .req_rmask_i(req_rmask), .req_wmask_i(req_wmask),
    .req_wdata_i(req_wdata), .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata),
    .rsp_err_i(rsp_err), .rvfi_bus_valid_o(d_valid), .rvfi_bus_insn_o(d_insn),
    .rvfi_bus_data_o(d_data), .rvfi_bus_fault_o(d_fault), .rvfi_bus_addr_o(d_addr),
    .rvfi_bus_rmask_o(d_rmask), .rvfi_bus_rdata_o(d_rdata), .rvfi_bus_wmask_o(d_wmask),
    .rvfi_bus_wdata_o(d_wdata), .pending_o(d_pend), .proto_err_o(d_err)
  );

  rvfi_bus_observer #(.XLEN(32), .BUSLEN(32), .DEPTH(DEPTH), .INSN(1'b1)) u_dut_insn (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_i(req_ready),
    .req_addr_i(req_addr), .req_rmask_i(req_rmask), .req_wmask_i(req_wmask),
    .req_wdata_i(req_wdata), .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata),
    .rsp_err_i(rsp_err), .rvfi_bus_valid_o(i_valid), .rvfi_bus_insn_o(i_insn),
    .rvfi_bus_data_o(i_data), .rvfi_bus_fault_o(i_fault), .rvfi_bus_addr_o(i_addr),
    .rvfi_bus_rmask_o(i_rmask), .rvfi_bus_rdata_o(i_rdata), .rvfi_bus_wmask_o(i_wmask),
    .rvfi_bus_wdata_o(i_wdata), .pending_o(i_pend), .proto_err_o(i_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
  } req_t;

  req_t        q[$];
  logic        e_valid, e_fault, e_err, e_seen;
  logic [31:0] e_addr, e_rdata, e_wdata;
  logic [3:0]  e_rmask, e_wmask;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    e_valid = 1'b0; e_fault = 1'b0; e_err = 1'b0; e_seen = 1'b0;
    e_addr = '0; e_rdata = '0; e_wdata = '0; e_rmask = '0; e_wmask = '0;
  endtask

  // Transaction-level view of one clock edge: retire the oldest request, then accept the new one.
  task automatic model_edge();
    req_t r;
    e_valid = 1'b0;
    if (rsp_valid) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        e_valid = 1'b1; e_seen = 1'b1;
        e_fault = rsp_err;
        e_addr  = r.addr;
        e_rmask = r.rm;
        e_wmask = r.wm;
        e_rdata = keep_bytes(rsp_rdata, r.rm);
        e_wdata = keep_bytes(r.wd, r.wm);
      end else begin
        e_err = 1'b1;
      end
    end
    if (req_valid && req_ready) begin
      if (q.size() < DEPTH) begin
        r.addr = req_addr; r.rm = req_rmask; r.wm = req_wmask; r.wd = req_wdata;
        q.push_back(r);
      end else begin
        e_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", 64'(d_valid), 64'(e_valid));
    chk("fault", 64'(d_fault), 64'(e_fault));
    chk("addr", 64'(d_addr), 64'(e_addr));
    chk("rmask", 64'(d_rmask), 64'(e_rmask));
    chk("rdata", 64'(d_rdata), 64'(e_rdata));
    chk("wmask", 64'(d_wmask), 64'(e_wmask));
    chk("wdata", 64'(d_wdata), 64'(e_wdata));
    chk("pending", 64'(d_pend), 64'(q.size()));
    chk("proto_err", 64'(d_err), 64'(e_err));
    chk("insn", 64'(d_insn), 64'(1'b0));
    chk("data", 64'(d_data), 64'(e_seen));
    chk("i_valid", 64'(i_valid), 64'(e_valid));
    chk("i_rdata", 64'(i_rdata), 64'(e_rdata));
    chk("i_pending", 64'(i_pend), 64'(q.size()));
    chk("i_insn", 64'(i_insn), 64'(e_seen));
    chk("i_data", 64'(i_data), 64'(1'b0));
  endtask

  task automatic step(input logic v, input logic rdy, input logic [31:0] a, input logic [3:0] rm,
                      input logic [3:0] wm, input logic [31:0] wd, input logic rv,
                      input logic [31:0] rd, input logic er);
    req_valid = v; req_ready = rdy; req_addr = a; req_rmask = rm; req_wmask = wm;
    req_wdata = wd; rsp_valid = rv; rsp_rdata = rd; rsp_err = er;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    req_valid = 1'b0; rsp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Read with partial byte enables
    step(1'b1, 1'b1, 32'h100, 4'b0011, 4'b0000, 32'h0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("t1_valid", 64'(d_valid), 64'd1);
    chk("t1_rdata", 64'(d_rdata), 64'h0000BEEF);
    chk("t1_addr", 64'(d_addr), 64'h100);
    chk("t1_i_insn", 64'(i_insn), 64'd1);
    idle();
    chk("t1_pulse", 64'(d_valid), 64'd0);

    // Write with bus error
    step(1'b1, 1'b1, 32'h204, 4'b0000, 4'b1100, 32'h11223344, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 32'hCAFEF00D, 1'b1);
    chk("t2_wdata", 64'(d_wdata), 64'h11220000);
    chk("t2_fault", 64'(d_fault), 64'd1);
    chk("t2_rmask", 64'(d_rmask), 64'd0);

    // Four pipelined requests, then four responses
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 32'h1000 + 32'(k * 4), 4'hF, 4'h0, '0, 1'b0, '0, 1'b0);
    chk("t3_full", 64'(d_pend), 64'd4);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, $urandom, 1'b0);
      chk("t3_order", 64'(d_addr), 64'h1000 + 64'(k * 4));
    end
    chk("t3_empty", 64'(d_pend), 64'd0);
    chk("t3_noerr", 64'(d_err), 64'd0);

    // Overflow, then full push with simultaneous pop
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b1, 32'h2000 + 32'(k), 4'h1, 4'h0, '0, 1'b0, '0, 1'b0);
    chk("t4_err", 64'(d_err), 64'd1);
    chk("t4_pend", 64'(d_pend), 64'd4);
    step(1'b1, 1'b1, 32'h3000, 4'h1, 4'h0, '0, 1'b1, 32'h55, 1'b0);
    chk("t4_pend_same", 64'(d_pend), 64'd4);
    chk("t4_head", 64'(d_addr), 64'h2000);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, $urandom, 1'b0);
    do_reset();

    // Spurious response, then same-cycle request+response with nothing pending
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 32'h77, 1'b0);
    chk("t5_norec", 64'(d_valid), 64'd0);
    chk("t5_err", 64'(d_err), 64'd1);
    do_reset();
    step(1'b1, 1'b1, 32'h400, 4'h0, 4'h0, '0, 1'b1, 32'h99, 1'b0);
    chk("t5b_err", 64'(d_err), 64'd1);
    chk("t5b_pend", 64'(d_pend), 64'd1);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 32'h99, 1'b1);
    chk("t5b_probe", 64'(d_valid), 64'd1);
    do_reset();

    // Reset with two requests outstanding
    step(1'b1, 1'b1, 32'h500, 4'hF, 4'h0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h504, 4'hF, 4'h0, '0, 1'b0, '0, 1'b0);
    chk("t6_pend2", 64'(d_pend), 64'd2);
    do_reset();
    chk("t6_pend0", 64'(d_pend), 64'd0);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 32'h1, 1'b0);
    chk("t6_err", 64'(d_err), 64'd1);
    do_reset();

    // Random traffic, including unready requests and occasional protocol violations
    for (int n = 0; n < 600; n++) begin
      logic rv;
      if (n == 300) do_reset();
      rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, $urandom, 4'($urandom),
           4'($urandom), $urandom, rv, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
